ex_muldiv_sequencer: RTL and testbench



---
 rtl/rv32m_pkg.sv | 30 +++
 rtl/muldiv_special_case.sv | 36 +++
 rtl/ex_muldiv_sequencer.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M encodings, sequencer state type and overflow constants.
// Rev 1.0
`default_nettype none

package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/muldiv_special_case.sv
// muldiv_special_case: detects divide-by-zero and signed overflow, which bypass iteration.
// Rev 1.0
`default_nettype none

module muldiv_special_case
  import rv32m_pkg::*;
#(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic [2:0]      funct_3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            fast_path,
  output logic [XLEN-1:0] fast_result
);

  logic div_zero;
  logic div_ovf;

  always_comb begin
    div_zero    = funct_3[2] && (rs2 == '0);
    div_ovf     = ((funct_3 == F3_DIV) || (funct_3 == F3_REM)) &&
                  (rs1 == OVF_DIVIDEND) && (rs2 == OVF_DIVISOR);
    fast_path   = div_zero || div_ovf;
    fast_result = '0;
    // funct_3[1] separates the remainder forms from the quotient forms
    if (div_zero) begin
      fast_result = funct_3[1] ? rs1 : '1;
    end else if (div_ovf) begin
      fast_result = funct_3[1] ? '0 : OVF_DIVIDEND;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: 32-iteration shift-add multiply / restoring divide for RV32M in EX.
// Rev 1.0
`default_nettype none

module ex_muldiv_sequencer
  import rv32m_pkg::*;
#(
  parameter int XLEN  = rv32m_pkg::XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct_3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  logic                fast_path;
  logic [XLEN-1:0]     fast_result;

  logic                s1_signed, s2_signed, neg1, neg2, neg_flag;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_sel;

  muldiv_special_case #(.XLEN(XLEN)) u_special (
    .funct_3     (funct_3),
    .rs1         (rs1),
    .rs2         (rs2),
    .fast_path   (fast_path),
    .fast_result (fast_result)
  );

  always_comb begin
    s1_signed = (funct_3 == F3_MULH) || (funct_3 == F3_MULHSU) ||
                (funct_3 == F3_DIV)  || (funct_3 == F3_REM);
    s2_signed = (funct_3 == F3_MULH) || (funct_3 == F3_DIV) || (funct_3 == F3_REM);
    neg1      = s1_signed && rs1[XLEN-1];
    neg2      = s2_signed && rs2[XLEN-1];
    a_mag     = neg1 ? -rs1 : rs1;
    b_mag     = neg2 ? -rs2 : rs2;
    // Remainder takes the dividend's sign; product and quotient take the XOR
    neg_flag  = (funct_3 == F3_REM) ? neg1 : (neg1 ^ neg2);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       fix_sel = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_sel = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_sel = quo_fix;
      default:                      fix_sel = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_d  = funct_3;
            neg_d = neg_flag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
            cnt_d = '0;
            if (fast_path) begin
              result_d = fast_result;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = f3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = fix_sel;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // A start that coincides with kill is never accepted, so it must not stall
  assign stall  = ((state_q == ST_IDLE) && start && !fast_path && !kill) ||
                  (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: vector table, randomized ops against an arithmetic model, abort cases.
// Rev 1.0
`default_nettype none

module tb_ex_muldiv_sequencer;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct_3 = 3'b000;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        stall, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .kill    (kill),
    .funct_3 (funct_3),
    .rs1     (rs1),
    .rs2     (rs2),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin up = ua * ub; return up[31:0]; end
      F3_MULH:   begin sp = sa * sb; return sp[63:32]; end
      F3_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
      F3_MULHU:  begin up = ua * ub; return up[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (((f3 == F3_DIV) || (f3 == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Cycle c is the interval ending at edge c; inputs change at edge+1, outputs sampled at edge+4.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int          done_cnt = 0;
    int          done_at = -1;
    logic [31:0] res_at = 32'h0;
    bit          stall_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; funct_3 = f3; rs1 = a; rs2 = b;
    #3;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0; funct_3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        #3;
      end
      if (stall !== (!fast && c <= 33)) stall_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = c; res_at = result; end
      end
    end
    check({tag, " result"}, res_at, exp);
    check({tag, " done_cycle"}, 32'(done_at), fast ? 32'd1 : 32'd34);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " stall_window"}, {31'h0, stall_ok}, 32'd1);
  endtask

  initial begin
    int          d_cnt, d1_at, d2_at, cnt;
    logic [31:0] d1_res, d2_res, prev, a, b;
    logic [2:0]  f3;
    logic        stall34;

    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0};
    vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0};
    vecs[8]  = '{F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{F3_REMU,   32'd5,          32'd0,         32'd5,         1'b1};
    vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b1};

    repeat (3) @(posedge clk);
    #4;
    check("reset stall", {31'h0, stall}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b,
             ref_model(f3, a, b), is_fast(f3, a, b));
    end

    // Kill in cycle 10 of a running multiply
    prev = result;
    @(posedge clk); #1;
    start = 1'b1; funct_3 = F3_MUL; rs1 = 32'd7; rs2 = 32'd9;
    #3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) kill = 1'b1;
      #3;
      if (c == 9) check("kill pre stall", {31'h0, stall}, 32'h1);
    end
    @(posedge clk); #1;
    kill = 1'b0;
    #3;
    check("kill stall c11", {31'h0, stall}, 32'h0);
    check("kill result held", result, prev);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #4;
      if (done === 1'b1) cnt++;
    end
    check("kill no done", 32'(cnt), 32'h0);

    // kill together with start in IDLE: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; funct_3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    #3;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    #3;
    check("kill+start stall c1", {31'h0, stall}, 32'h0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #4;
      if (done === 1'b1) cnt++;
    end
    check("kill+start no done", 32'(cnt), 32'h0);

    // start held through DONE, second op issued in cycle 35
    d_cnt = 0; d1_at = -1; d2_at = -1; d1_res = 32'h0; d2_res = 32'h0; stall34 = 1'bx;
    @(posedge clk); #1;
    start = 1'b1; funct_3 = F3_MUL; rs1 = 32'd5; rs2 = 32'd6;
    #3;
    for (int c = 0; c <= 75; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 35) begin rs1 = 32'd3; rs2 = 32'd4; end
        start = (c <= 35);
        #3;
      end
      if (c == 34) stall34 = stall;
      if (done === 1'b1) begin
        d_cnt++;
        if (d1_at < 0) begin d1_at = c; d1_res = result; end
        else if (d2_at < 0) begin d2_at = c; d2_res = result; end
      end
    end
    check("b2b done count", 32'(d_cnt), 32'd2);
    check("b2b first done cycle", 32'(d1_at), 32'd34);
    check("b2b first result", d1_res, 32'd30);
    check("b2b second done cycle", 32'(d2_at), 32'd69);
    check("b2b second result", d2_res, 32'd12);
    check("b2b stall in DONE", {31'h0, stall34}, 32'h0);

    // Asynchronous reset in cycle 20 of a divide
    @(posedge clk); #1;
    start = 1'b1; funct_3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    #3;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #3;
    end
    check("rst pre stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst async stall", {31'h0, stall}, 32'h0);
    check("rst async result", result, 32'h0);
    check("rst async done", {31'h0, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset", vecs[6].f3, vecs[6].a, vecs[6].b, vecs[6].exp, vecs[6].fast);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
